// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter between instruction fetch (IF) and load/store (LS).
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin instead of LS priority with starvation guard.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_ls_req,
  input  logic        i_ls_we,
  input  logic [31:0] i_ls_addr,
  input  logic [31:0] i_ls_wdata,
  input  logic [3:0]  i_ls_be,
  output logic        o_ls_gnt,
  output logic        o_ls_rvalid,
  output logic [31:0] o_ls_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_mux_sel
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e      state_q, state_d;
  logic        sel_q, sel_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        ls_win;

`ifdef ARB_ROUND_ROBIN_EN
  // Reset value 1 makes IF the first winner of a contested arbitration.
  logic last_ls_q, last_ls_d;

  assign ls_win = i_ls_req && (!i_if_req || !last_ls_q);
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_q, starve_d;

  assign ls_win = i_ls_req && (!i_if_req || (starve_q != LIMIT));
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_ls_d = last_ls_q;
`else
    starve_d  = starve_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifndef ARB_ROUND_ROBIN_EN
        // Count only LS wins that kept a pending fetch waiting; anything else resets the guard.
        if (!i_if_req || !ls_win)    starve_d = '0;
        else if (starve_q != LIMIT)  starve_d = starve_q + 4'd1;
`endif
        if (i_if_req || i_ls_req) begin
          state_d = ISSUE;
          sel_d   = ls_win;
`ifdef ARB_ROUND_ROBIN_EN
          last_ls_d = ls_win;
`endif
          if (ls_win) begin
            we_d    = i_ls_we;
            addr_d  = i_ls_addr;
            wdata_d = i_ls_wdata;
            be_d    = i_ls_be;
          end else begin
            we_d    = 1'b0;
            addr_d  = i_if_addr;
            wdata_d = '0;
            be_d    = '1;
          end
        end
      end
      ISSUE: if (i_mem_ready)  state_d = WAIT;
      WAIT:  if (i_mem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_ls_q <= 1'b1;
`else
      starve_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_ls_q <= last_ls_d;
`else
      starve_q  <= starve_d;
`endif
    end
  end

  assign o_mem_req   = (state_q == ISSUE);
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_be    = be_q;
  assign o_mux_sel   = sel_q;

  assign o_if_gnt    = (state_q == ISSUE) && i_mem_ready && !sel_q;
  assign o_ls_gnt    = (state_q == ISSUE) && i_mem_ready &&  sel_q;
  assign o_if_rvalid = (state_q == WAIT) && i_mem_rvalid && !sel_q;
  assign o_ls_rvalid = (state_q == WAIT) && i_mem_rvalid &&  sel_q;
  assign o_if_rdata  = i_mem_rdata;
  assign o_ls_rdata  = i_mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (inputs driven at negedge, checked 1ns later).
module tb_mem_port_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt, o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_ls_req, i_ls_we;
  logic [31:0] i_ls_addr, i_ls_wdata;
  logic [3:0]  i_ls_be;
  logic        o_ls_gnt, o_ls_rvalid;
  logic [31:0] o_ls_rdata;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_ready, i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_mux_sel;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 i_clk = ~i_clk;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_addr(i_ls_addr),
    .i_ls_wdata(i_ls_wdata), .i_ls_be(i_ls_be),
    .o_ls_gnt(o_ls_gnt), .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
    .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_mux_sel(o_mux_sel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge (mid-cycle), where inputs are changed.
  task automatic cyc();
    @(negedge i_clk);
  endtask

  initial begin
    logic exp_ls [6];

    i_rst_n = 1'b0;
    i_if_req = 1'b0; i_if_addr = '0;
    i_ls_req = 1'b0; i_ls_we = 1'b0; i_ls_addr = '0; i_ls_wdata = '0; i_ls_be = '0;
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    cyc(); cyc(); #1;
    chk("rst_mem_req", 32'(o_mem_req), 32'd0);
    chk("rst_mux_sel", 32'(o_mux_sel), 32'd0);
    chk("rst_addr", o_mem_addr, 32'd0);
    chk("rst_be", 32'(o_mem_be), 32'd0);
    chk("rst_gnts", {30'd0, o_if_gnt, o_ls_gnt}, 32'd0);
    cyc(); i_rst_n = 1'b1;

    // Single fetch, minimum latency
    cyc(); i_if_req = 1'b1; i_if_addr = 32'h0000_0100; i_mem_ready = 1'b1; #1;
    chk("f_c0_req", 32'(o_mem_req), 32'd0);
    cyc(); #1;
    chk("f_c1_req", 32'(o_mem_req), 32'd1);
    chk("f_c1_gnt", 32'(o_if_gnt), 32'd1);
    chk("f_c1_lsgnt", 32'(o_ls_gnt), 32'd0);
    chk("f_c1_addr", o_mem_addr, 32'h0000_0100);
    chk("f_c1_be", 32'(o_mem_be), 32'hF);
    chk("f_c1_we", 32'(o_mem_we), 32'd0);
    chk("f_c1_sel", 32'(o_mux_sel), 32'd0);
    cyc(); i_if_req = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0000_0013; #1;
    chk("f_c2_req", 32'(o_mem_req), 32'd0);
    chk("f_c2_rvalid", 32'(o_if_rvalid), 32'd1);
    chk("f_c2_rdata", o_if_rdata, 32'h0000_0013);
    chk("f_c2_lsrv", 32'(o_ls_rvalid), 32'd0);
    cyc(); i_mem_rvalid = 1'b0; #1;
    chk("f_c3_rvalid", 32'(o_if_rvalid), 32'd0);

    // Store with 3 stall cycles
    i_ls_req = 1'b1; i_ls_we = 1'b1; i_ls_addr = 32'h2000_0004;
    i_ls_wdata = 32'hDEAD_BEEF; i_ls_be = 4'b0011; i_mem_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cyc(); #1;
      chk($sformatf("st_stall%0d_req", i), 32'(o_mem_req), 32'd1);
      chk($sformatf("st_stall%0d_gnt", i), 32'(o_ls_gnt), 32'd0);
      chk($sformatf("st_stall%0d_addr", i), o_mem_addr, 32'h2000_0004);
      chk($sformatf("st_stall%0d_wdata", i), o_mem_wdata, 32'hDEAD_BEEF);
      chk($sformatf("st_stall%0d_be", i), 32'(o_mem_be), 32'h3);
      chk($sformatf("st_stall%0d_we", i), 32'(o_mem_we), 32'd1);
      chk($sformatf("st_stall%0d_sel", i), 32'(o_mux_sel), 32'd1);
    end
    cyc(); i_mem_ready = 1'b1; #1;
    chk("st_c4_req", 32'(o_mem_req), 32'd1);
    chk("st_c4_gnt", 32'(o_ls_gnt), 32'd1);
    chk("st_c4_ifgnt", 32'(o_if_gnt), 32'd0);
    cyc(); i_ls_req = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h1234_5678; #1;
    chk("st_ack", 32'(o_ls_rvalid), 32'd1);
    chk("st_if_rv", 32'(o_if_rvalid), 32'd0);
    cyc(); i_mem_rvalid = 1'b0; #1;

    // Spurious rvalid in IDLE then in ISSUE
    i_mem_rvalid = 1'b1; #1;
    chk("sp_idle_rv", {30'd0, o_if_rvalid, o_ls_rvalid}, 32'd0);
    cyc(); #1;
    chk("sp_idle_stay", 32'(o_mem_req), 32'd0);
    i_if_req = 1'b1; i_if_addr = 32'h0000_0200; i_mem_ready = 1'b0;
    cyc(); #1;
    chk("sp_issue_rv", {30'd0, o_if_rvalid, o_ls_rvalid}, 32'd0);
    chk("sp_issue_req", 32'(o_mem_req), 32'd1);
    cyc(); #1;
    chk("sp_issue_stay", 32'(o_mem_req), 32'd1);
    i_mem_rvalid = 1'b0; i_mem_ready = 1'b1; #1;
    chk("sp_gnt", 32'(o_if_gnt), 32'd1);
    cyc(); i_if_req = 1'b0; i_mem_rvalid = 1'b1; #1;
    chk("sp_rv", 32'(o_if_rvalid), 32'd1);

    // Both pending continuously
`ifdef ARB_ROUND_ROBIN_EN
    exp_ls = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_ls = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`endif
    for (int r = 0; r < 6; r++) begin
      cyc(); i_mem_rvalid = 1'b0;
      i_if_req = 1'b1; i_if_addr = 32'h0000_0400;
      i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 32'h0000_3000; i_ls_be = 4'hF;
      cyc(); #1;
      chk($sformatf("sv%0d_lsgnt", r), 32'(o_ls_gnt), 32'(exp_ls[r]));
      chk($sformatf("sv%0d_ifgnt", r), 32'(o_if_gnt), 32'(!exp_ls[r]));
      chk($sformatf("sv%0d_sel", r), 32'(o_mux_sel), 32'(exp_ls[r]));
      chk($sformatf("sv%0d_addr", r), o_mem_addr, exp_ls[r] ? 32'h0000_3000 : 32'h0000_0400);
      cyc(); i_mem_rvalid = 1'b1;
    end

    // Back-to-back zero-wait LS loads
    for (int c = 0; c < 9; c++) begin
      cyc(); i_if_req = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'(c); #1;
      chk($sformatf("bb%0d_gnt", c), 32'(o_ls_gnt), 32'((c % 3) == 1));
      chk($sformatf("bb%0d_rv", c), 32'(o_ls_rvalid), 32'((c % 3) == 2));
      if (c >= 1) chk($sformatf("bb%0d_sel", c), 32'(o_mux_sel), 32'd1);
    end

    // Reset during WAIT
    cyc(); i_ls_req = 1'b0; i_mem_rvalid = 1'b0;
    i_if_req = 1'b1; i_if_addr = 32'h0000_0500;
    cyc(); #1;
    chk("rw_gnt", 32'(o_if_gnt), 32'd1);
    cyc(); i_if_req = 1'b0; i_mem_rvalid = 1'b1; i_rst_n = 1'b0; #1;
    chk("rw_req", 32'(o_mem_req), 32'd0);
    chk("rw_addr", o_mem_addr, 32'd0);
    chk("rw_be", 32'(o_mem_be), 32'd0);
    chk("rw_rv", {30'd0, o_if_rvalid, o_ls_rvalid}, 32'd0);
    cyc(); i_rst_n = 1'b1; #1;
    chk("rw_late_rv", {30'd0, o_if_rvalid, o_ls_rvalid}, 32'd0);
    cyc(); i_mem_rvalid = 1'b0; i_if_req = 1'b1; i_if_addr = 32'h0000_0600; #1;
    cyc(); #1;
    chk("rw_new_gnt", 32'(o_if_gnt), 32'd1);
    chk("rw_new_addr", o_mem_addr, 32'h0000_0600);
    cyc(); i_if_req = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hCAFE_0001; #1;
    chk("rw_new_rv", 32'(o_if_rvalid), 32'd1);
    chk("rw_new_rdata", o_if_rdata, 32'hCAFE_0001);
    cyc(); i_mem_rvalid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single unified memory port of the RV32I core between the instruction-fetch requester (IF) and the load/store requester (LS). It owns the port-select register that drives the 2:1 address/write-data selection in front of memory, latches the winning request, sequences a single outstanding transaction, and routes the response back to the owner. It sits between the fetch stage and the LSU on one side and the memory interface on the other.

## Interface
- STARVE_LIMIT, 4: consecutive LS grants allowed while IF is pending before IF is forced (range 1..15)
- i_clk  in  1  core clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_if_req  in  1  fetch request; held with payload until o_if_gnt
- i_if_addr  in  32  fetch word address
- o_if_gnt  out  1  one-cycle pulse: fetch accepted by memory
- o_if_rvalid  out  1  fetch data valid
- o_if_rdata  out  32  fetch data
- i_ls_req  in  1  load/store request; held with payload until o_ls_gnt
- i_ls_we  in  1  1 = store, 0 = load
- i_ls_addr  in  32  data address
- i_ls_wdata  in  32  store data
- i_ls_be  in  4  byte enables
- o_ls_gnt  out  1  one-cycle pulse: LS accepted by memory
- o_ls_rvalid  out  1  LS completion (load data or store ack)
- o_ls_rdata  out  32  load data
- o_mem_req  out  1  memory request valid
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  32  memory address
- o_mem_wdata  out  32  memory write data
- o_mem_be  out  4  memory byte enables (4'hF for fetch)
- i_mem_ready  in  1  memory accepts o_mem_req this cycle
- i_mem_rvalid  in  1  response/ack valid (reads and writes)
- i_mem_rdata  in  32  read data
- o_mux_sel  out  1  port owner / select: 0 = IF, 1 = LS

## Operation
- FSM: IDLE, ISSUE, WAIT. Reset: IDLE, o_mux_sel=0, starve count=0, all o_mem_* and payload registers 0.
- IDLE: if any req, choose winner, latch its payload into o_mem_addr/we/wdata/be, set o_mux_sel, go ISSUE. No req: stay, o_mux_sel holds last owner.
- Default policy: LS wins when both pending, unless starve count == STARVE_LIMIT, then IF wins.
- Starve count: +1 on LS win with i_if_req high; cleared on IF win or IDLE cycle with i_if_req low; saturates at STARVE_LIMIT.
- ISSUE: o_mem_req=1 with latched payload held stable. When i_mem_ready=1: pulse owner's gnt that cycle, go WAIT.
- WAIT: o_mem_req=0. On i_mem_rvalid: owner's rvalid=1 combinationally, rdata=i_mem_rdata, go IDLE. Non-owner rvalid stays 0.
- o_if_rdata/o_ls_rdata pass i_mem_rdata always; only rvalid qualifies.
- i_mem_rvalid in IDLE or ISSUE: ignored, not forwarded.
- Requester dropping req before gnt: protocol violation; latched transaction still completes, gnt/rvalid still asserted.
- Fetch: o_mem_we=0, o_mem_be=4'hF, o_mem_wdata=0.

## Timing
- One outstanding transaction. Decision cycle (IDLE) registered; request visible on o_mem_req the following cycle.
- Minimum: req sampled cycle 0 -> o_mem_req + gnt cycle 1 (ready=1) -> rvalid cycle 2 (earliest) -> IDLE cycle 3, next arbitration cycle 3. Peak throughput 1 transaction / 3 cycles.
- Memory stall: ISSUE holds indefinitely while i_mem_ready=0; WAIT holds indefinitely while i_mem_rvalid=0.
- o_mux_sel changes only on IDLE->ISSUE edge; stable for whole transaction.
- Async reset at any state: next state IDLE immediately, o_mem_req=0, gnt/rvalid 0; in-flight response after reset deassertion is dropped (arrives in IDLE).

## Configuration
- ARB_ROUND_ROBIN_EN defined: starvation counter removed; when both pending, winner is the requester that did not win the previous arbitration (after reset, IF first); STARVE_LIMIT ignored.
- Not defined: LS priority with STARVE_LIMIT starvation guard as above.

## Test plan
- Single fetch, i_if_addr=32'h0000_0100, ready=1, rvalid+rdata=32'h0000_0013 one cycle after gnt -> o_mem_req cycle 1, o_if_gnt cycle 1, o_if_rvalid cycle 2 with 32'h13, o_mux_sel=0, o_mem_be=4'hF.
- Store, addr=32'h2000_0004, wdata=32'hDEAD_BEEF, be=4'b0011, ready low 3 cycles -> o_mem_req held 4 cycles with stable payload, o_ls_gnt on 4th, o_ls_rvalid on ack, o_if_rvalid never.
- IF and LS held pending continuously, STARVE_LIMIT=4 -> grant order LS,LS,LS,LS,IF,LS,... (round-robin build: IF,LS,IF,LS).
- Spurious i_mem_rvalid in IDLE and ISSUE -> no rvalid to either requester, FSM state unchanged.
- Reset asserted in WAIT after gnt -> outputs zero immediately; after release, late i_mem_rvalid ignored; new IF req served normally.
- Back-to-back LS loads with zero-wait memory -> gnts exactly 3 cycles apart, o_mux_sel stays 1.
